avalon_pio_out_pulse: RTL and testbench
=======================================

Name: avalon_pio_out_pulse

Overview:
Parametrised Avalon-MM output PIO, successor to the fixed 3-bit set/clear output port.
- Generalises port width and reset value.
- Adds per-bit toggle and a hardware auto-clear pulse mode driven by a shared programmable countdown timer.
- Sits on the system interconnect as a zero-wait-state slave driving board-level control lines (codec select, enables, strobes).

Parameters:
WIDTH, 8, output port width in bits (1..32)
PULSE_W, 16, width of pulse-length register and countdown counter
RESET_VALUE, 0, value loaded into data_out at reset (WIDTH bits)
DEFAULT_PULSE_LEN, 1, reset value of PULSE_LEN register (PULSE_W bits)

Ports:
clk  in  1  system clock; all state on rising edge
reset_n  in  1  synchronous, active-low reset
address  in  3  word address of register
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data; bits above WIDTH/PULSE_W ignored
readdata  out  32  read data, combinational from address, zero-extended
out_port  out  WIDTH  registered output lines (= data_out)
irq  out  1  pulse-done interrupt (see Optional Feature)

Behaviour:
Clock and reset:
- One clock, clk; reset is synchronous and active-low on reset_n, sampled on the rising edge of clk.
- Reset values: data_out=RESET_VALUE, pulse_len=DEFAULT_PULSE_LEN, pulse_mask=0, counter=0, busy=0, irq=0.
- Reset mid-pulse aborts the pulse; no expiry event.

Write strobe and latency:
- wr = chipselect & ~write_n, one write per cycle.
- Register effect is visible on out_port the cycle after the write edge.
- Reads have no side effects.

Register map (W = WIDTH):
- 0 DATA: W data_out <= wd; R data_out.
- 1 PULSE_LEN: W pulse_len <= wd[PULSE_W-1:0]; R pulse_len.
- 2 STATUS: R {busy at bit 31, pulse_mask in bits W-1:0}; W clears irq (any data).
- 3: reserved; reads 0, writes ignored.
- 4 SET: W data_out |= wd.
- 5 CLEAR: W data_out &= ~wd.
- 6 TOGGLE: W data_out ^= wd.
- 7 PULSE: W data_out |= wd; starts a pulse (below); R 0.

Pulse mode:
- Effective length N = max(pulse_len, 1).
- PULSE write with wd != 0:
  - pulse_mask <= pulse_mask | wd;
  - counter <= N; busy <= 1.
  - Bits in wd stay high exactly N cycles after the write edge.
- PULSE write with wd = 0: no effect.
- While busy, counter decrements each cycle.
- Expiry occurs on the cycle counter==1 & busy:
  - data_out &= ~pulse_mask;
  - pulse_mask <= 0; busy <= 0; irq event.
- Retrigger: a PULSE write while busy ORs the new bits into the mask and reloads counter <= N. All masked bits end together.
- CPU override: a DATA/SET/CLEAR/TOGGLE write removes every bit set in wd (DATA: all bits) from pulse_mask.
  - Overridden bits keep the value written and are not cleared at expiry.
  - If the mask becomes 0, busy <= 0 and counter <= 0 with no irq event.

Simultaneous expiry and write (same cycle): expiry is applied first, then the write to the post-expiry value.
- PULSE write in the expiry cycle: old bits clear, new bits set, mask = new bits only, counter = N, busy stays 1, irq event still raised.
- DATA/SET/CLEAR/TOGGLE write in the expiry cycle: written value wins for bits in wd.

Width rules:
- pulse_len of 0 is treated as 1.
- The counter never wraps: it is held at 0 when not busy.

Optional Feature:
Macro PIO_PULSE_IRQ_EN.
- Defined:
  - irq is a sticky register set on every expiry event and cleared by a STATUS write.
  - Expiry in the same cycle as a STATUS write leaves irq = 1 (set wins).
  - STATUS bit 30 reads irq.
- Not defined:
  - irq tied to 0; STATUS bit 30 reads 0; STATUS writes ignored.

Test Plan:
- Reset with WIDTH=8, RESET_VALUE=8'hA5 -> out_port=8'hA5, STATUS=0, PULSE_LEN reads 1, irq=0.
- DATA=8'h0F; SET 8'h30; CLEAR 8'h03; TOGGLE 8'hFF -> out_port 0F, 3F, 3C, C3 on successive cycles after each write.
- PULSE_LEN=5; PULSE 8'h81 from out_port=0 -> bits 7,0 high exactly 5 cycles then 0; busy high for the same window; irq=1 (IRQ_EN); STATUS write -> irq=0.
- PULSE_LEN=4; PULSE 8'h01, then PULSE 8'h02 two cycles later -> both bits clear together 4 cycles after the second write; exactly one irq event.
- PULSE_LEN=6; PULSE 8'h03, then CLEAR 8'h01 during pulse -> bit0 low immediately, bit1 clears at expiry; then PULSE 8'h04 with CLEAR 8'h04 -> mask empty, busy=0, no irq.
- PULSE_LEN=0 -> 1-cycle pulse. PULSE write in the expiry cycle of a running pulse -> old bits clear, new bits high N cycles. reset_n=0 mid-pulse -> next cycle out_port=RESET_VALUE, busy=0, irq=0.

Source files
------------

// File: rtl/avalon_pio_out_pulse.sv
// Avalon-MM output PIO with set/clear/toggle registers and timed auto-clear pulses.
// Optional sticky pulse-done interrupt is enabled by defining PIO_PULSE_IRQ_EN.
module avalon_pio_out_pulse #(
  parameter int                   WIDTH             = 8,
  parameter int                   PULSE_W           = 16,
  parameter logic [WIDTH-1:0]     RESET_VALUE       = '0,
  parameter logic [PULSE_W-1:0]   DEFAULT_PULSE_LEN = PULSE_W'(1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port,
  output logic              irq
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_LEN    = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;
  localparam logic [2:0] ADDR_SET    = 3'd4;
  localparam logic [2:0] ADDR_CLEAR  = 3'd5;
  localparam logic [2:0] ADDR_TOGGLE = 3'd6;
  localparam logic [2:0] ADDR_PULSE  = 3'd7;

  logic [WIDTH-1:0]   data_out, data_nxt;
  logic [WIDTH-1:0]   pulse_mask, mask_nxt;
  logic [PULSE_W-1:0] pulse_len, len_nxt;
  logic [PULSE_W-1:0] counter, counter_nxt;
  logic [PULSE_W-1:0] len_eff;
  logic               busy, busy_nxt;
  logic               wr, expire, override;
  logic [WIDTH-1:0]   wd;
  logic               unused_writedata;

  assign wr      = chipselect & ~write_n;
  assign wd      = writedata[WIDTH-1:0];
  assign len_eff = (pulse_len == '0) ? PULSE_W'(1) : pulse_len;
  assign expire  = busy && (counter == PULSE_W'(1));
  assign unused_writedata = &{1'b0, writedata};

  // Expiry is resolved first; the bus write then acts on the post-expiry value.
  always_comb begin
    data_nxt    = data_out;
    mask_nxt    = pulse_mask;
    len_nxt     = pulse_len;
    counter_nxt = busy ? counter - PULSE_W'(1) : counter;
    busy_nxt    = busy;
    override    = 1'b0;

    if (expire) begin
      data_nxt    = data_out & ~pulse_mask;
      mask_nxt    = '0;
      busy_nxt    = 1'b0;
      counter_nxt = '0;
    end

    if (wr) begin
      unique case (address)
        ADDR_DATA: begin
          data_nxt = wd;
          mask_nxt = '0;
          override = 1'b1;
        end
        ADDR_LEN: len_nxt = writedata[PULSE_W-1:0];
        ADDR_SET: begin
          data_nxt = data_nxt | wd;
          mask_nxt = mask_nxt & ~wd;
          override = 1'b1;
        end
        ADDR_CLEAR: begin
          data_nxt = data_nxt & ~wd;
          mask_nxt = mask_nxt & ~wd;
          override = 1'b1;
        end
        ADDR_TOGGLE: begin
          data_nxt = data_nxt ^ wd;
          mask_nxt = mask_nxt & ~wd;
          override = 1'b1;
        end
        ADDR_PULSE: begin
          if (wd != '0) begin
            data_nxt    = data_nxt | wd;
            mask_nxt    = mask_nxt | wd;
            counter_nxt = len_eff;
            busy_nxt    = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // A CPU write that empties the mask cancels the pulse silently.
    if (override && mask_nxt == '0) begin
      busy_nxt    = 1'b0;
      counter_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out   <= RESET_VALUE;
      pulse_mask <= '0;
      pulse_len  <= DEFAULT_PULSE_LEN;
      counter    <= '0;
      busy       <= 1'b0;
    end else begin
      data_out   <= data_nxt;
      pulse_mask <= mask_nxt;
      pulse_len  <= len_nxt;
      counter    <= counter_nxt;
      busy       <= busy_nxt;
    end
  end

`ifdef PIO_PULSE_IRQ_EN
  logic irq_q;

  // Set on expiry takes priority over a clearing STATUS write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else if (expire) begin
      irq_q <= 1'b1;
    end else if (wr && address == ADDR_STATUS) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_DATA: readdata = 32'(data_out);
      ADDR_LEN:  readdata = 32'(pulse_len);
      ADDR_STATUS: begin
        readdata     = 32'(pulse_mask);
        readdata[31] = busy;
        readdata[30] = irq;
      end
      default: readdata = '0;
    endcase
  end

  assign out_port = data_out;

endmodule

// File: tb/tb_avalon_pio_out_pulse.sv
// Self-checking bench for avalon_pio_out_pulse: directed scenarios followed by
// randomized bus traffic, compared against a deadline-based behavioural model.
module tb_avalon_pio_out_pulse;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Model state: pulse end is an absolute edge number rather than a countdown.
  logic [7:0]  m_out;
  logic [7:0]  m_mask;
  logic [15:0] m_len;
  logic        m_irq;
  int          edge_no = 0;
  int          deadline = 0;

  avalon_pio_out_pulse #(
    .WIDTH(8),
    .PULSE_W(16),
    .RESET_VALUE(8'hA5),
    .DEFAULT_PULSE_LEN(16'd1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] expRead(input logic [2:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      3'd0: r = {24'd0, m_out};
      3'd1: r = {16'd0, m_len};
      3'd2: begin
        r = {24'd0, m_mask};
        r[31] = (m_mask != 8'd0);
`ifdef PIO_PULSE_IRQ_EN
        r[30] = m_irq;
`endif
      end
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic modelEdge(input bit w, input logic [2:0] a, input logic [31:0] d);
    logic [7:0] b;
    bit expired;
    b = d[7:0];
    expired = 1'b0;
    if (!reset_n) begin
      m_out = 8'hA5; m_mask = 8'd0; m_len = 16'd1; m_irq = 1'b0;
    end else begin
      if (m_mask != 8'd0 && edge_no == deadline) begin
        m_out  = m_out & ~m_mask;
        m_mask = 8'd0;
        expired = 1'b1;
      end
`ifdef PIO_PULSE_IRQ_EN
      if (w && a == 3'd2) m_irq = 1'b0;
      if (expired) m_irq = 1'b1;
`endif
      if (w) begin
        case (a)
          3'd0: begin m_out = b; m_mask = 8'd0; end
          3'd1: m_len = d[15:0];
          3'd4: begin m_out = m_out | b;  m_mask = m_mask & ~b; end
          3'd5: begin m_out = m_out & ~b; m_mask = m_mask & ~b; end
          3'd6: begin m_out = m_out ^ b;  m_mask = m_mask & ~b; end
          3'd7: if (b != 8'd0) begin
            m_out = m_out | b;
            m_mask = m_mask | b;
            deadline = edge_no + ((m_len == 16'd0) ? 1 : int'(m_len));
          end
          default: ;
        endcase
      end
    end
    edge_no++;
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (out_port === m_out) else begin
      errors++;
      $error("[TB] FAIL %s out_port got %h expected %h", tag, out_port, m_out);
    end
    checks++;
    assert (irq === m_irq) else begin
      errors++;
      $error("[TB] FAIL %s irq got %b expected %b", tag, irq, m_irq);
    end
  endtask

  task automatic checkRead(input string tag, input logic [2:0] a);
    logic [31:0] e;
    e = expRead(a);
    checks++;
    assert (readdata === e) else begin
      errors++;
      $error("[TB] FAIL %s readdata[%0d] got %h expected %h", tag, a, readdata, e);
    end
  endtask

  // One bus cycle: drive, check the combinational read, clock, check state.
  task automatic applyStimulus(input string tag, input bit w, input logic [2:0] a,
                               input logic [31:0] d);
    int r;
    address = a;
    writedata = d;
    if (w) begin
      chipselect = 1'b1; write_n = 1'b0;
    end else begin
      r = $urandom_range(0, 2);
      chipselect = (r == 1);
      write_n = (r != 2);
    end
    #1;
    if (reset_n) checkRead(tag, a);
    @(posedge clk);
    modelEdge(w, a, d);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input string tag, input int n, input logic [2:0] a);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, a, $urandom);
  endtask

  initial begin
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    m_out = 8'h00; m_mask = 8'h00; m_len = 16'd0; m_irq = 1'b0;
    @(negedge clk);
    applyStimulus("reset", 1'b0, 3'd0, 32'd0);
    applyStimulus("reset", 1'b0, 3'd0, 32'd0);
    reset_n = 1'b1;
    applyStimulus("rst_status", 1'b0, 3'd2, 32'd0);
    applyStimulus("rst_len", 1'b0, 3'd1, 32'd0);
    applyStimulus("rst_data", 1'b0, 3'd0, 32'd0);

    applyStimulus("data", 1'b1, 3'd0, 32'hFFFF_FF0F);
    applyStimulus("set", 1'b1, 3'd4, 32'h0000_0030);
    applyStimulus("clear", 1'b1, 3'd5, 32'h0000_0003);
    applyStimulus("toggle", 1'b1, 3'd6, 32'h0000_00FF);
    applyStimulus("rd_pulse", 1'b0, 3'd7, 32'd0);
    applyStimulus("rd_rsvd", 1'b1, 3'd3, 32'hFFFF_FFFF);

    applyStimulus("len5", 1'b1, 3'd1, 32'd5);
    applyStimulus("zero", 1'b1, 3'd0, 32'd0);
    applyStimulus("pulse81", 1'b1, 3'd7, 32'h81);
    idle("pulse81_run", 6, 3'd2);
    applyStimulus("irq_clr", 1'b1, 3'd2, 32'h1234);
    applyStimulus("irq_clr_rd", 1'b0, 3'd2, 32'd0);

    applyStimulus("len4", 1'b1, 3'd1, 32'd4);
    applyStimulus("pulse01", 1'b1, 3'd7, 32'h01);
    applyStimulus("retrig_gap", 1'b0, 3'd2, 32'd0);
    applyStimulus("pulse02", 1'b1, 3'd7, 32'h02);
    idle("retrig_run", 5, 3'd2);
    applyStimulus("irq_clr2", 1'b1, 3'd2, 32'd0);

    applyStimulus("len6", 1'b1, 3'd1, 32'd6);
    applyStimulus("pulse03", 1'b1, 3'd7, 32'h03);
    applyStimulus("ovr_gap", 1'b0, 3'd2, 32'd0);
    applyStimulus("clr01", 1'b1, 3'd5, 32'h01);
    idle("ovr_run", 6, 3'd2);
    applyStimulus("pulse04", 1'b1, 3'd7, 32'h04);
    applyStimulus("clr04", 1'b1, 3'd5, 32'h04);
    idle("cancel_run", 8, 3'd2);
    applyStimulus("pulse00", 1'b1, 3'd7, 32'h00);
    applyStimulus("pulse00_rd", 1'b0, 3'd2, 32'd0);

    applyStimulus("len0", 1'b1, 3'd1, 32'hFFFF_0000);
    applyStimulus("pulse10", 1'b1, 3'd7, 32'h10);
    idle("len0_run", 2, 3'd2);
    applyStimulus("len3", 1'b1, 3'd1, 32'd3);
    applyStimulus("pulse20", 1'b1, 3'd7, 32'h20);
    idle("pre_expiry", 2, 3'd2);
    applyStimulus("status_w_exp", 1'b1, 3'd2, 32'd0);
    applyStimulus("pulse40", 1'b1, 3'd7, 32'h40);
    idle("pre_expiry2", 2, 3'd2);
    applyStimulus("pulse_at_exp", 1'b1, 3'd7, 32'h08);
    idle("new_pulse_run", 4, 3'd2);
    applyStimulus("pulse08", 1'b1, 3'd7, 32'h08);
    reset_n = 1'b0;
    applyStimulus("mid_reset", 1'b0, 3'd2, 32'd0);
    reset_n = 1'b1;
    applyStimulus("after_reset", 1'b0, 3'd2, 32'd0);
    idle("after_reset_idle", 3, 3'd2);

    for (int i = 0; i < 600; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = (a == 3'd1) ? $urandom_range(0, 5) | ($urandom & 32'hFFFF_0000)
                      : ($urandom & $urandom & 32'hFFFF_FFFF);
      reset_n = ($urandom_range(0, 149) != 0);
      applyStimulus("random", ($urandom_range(0, 2) == 0), a, d);
    end
    reset_n = 1'b1;
    idle("final", 8, 3'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
